// File: rtl/ahbl_sram_pkg.sv
// Shared encodings, FSM state type and width helper for the AHB-Lite to SRAM bridge.
package ahbl_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_ERR1    = 3'd3,
        ST_ERR2    = 3'd4
    } bridge_state_e;

    function automatic int ceil_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ahbl_lane_decode.sv
// Address-phase decode: byte-lane enables, SRAM word address and transfer error flag.
module ahbl_lane_decode
    import ahbl_sram_pkg::*;
#(
    parameter  int DWIDTH     = 32,
    parameter  int MEM_DEPTH  = 65536,
    localparam int NB         = DWIDTH / 8,
    localparam int BL         = ceil_log2(NB),
    localparam int MEM_AWIDTH = ceil_log2(MEM_DEPTH)
) (
    input  logic [31:0]           haddr_i,
    input  logic [2:0]            hsize_i,
    output logic [NB-1:0]         byteen_o,
    output logic [MEM_AWIDTH-1:0] word_addr_o,
    output logic                  err_o
);

    logic [BL-1:0] offset;
    logic [31:0]   size_bytes;
    logic [31:0]   lane_mask;
    logic          size_err;
    logic          align_err;
    logic          range_err;

    // Oversized transfers wrap the mask to all-ones; they are flagged as errors anyway.
    always_comb begin
        offset      = haddr_i[BL-1:0];
        size_bytes  = 32'd1 << hsize_i;
        lane_mask   = (32'd1 << size_bytes) - 32'd1;
        byteen_o    = NB'(lane_mask << offset);
        word_addr_o = haddr_i[MEM_AWIDTH+BL-1:BL];
        size_err    = 32'(hsize_i) > 32'(BL);
        align_err   = (32'(offset) & (size_bytes - 32'd1)) != 32'd0;
        range_err   = 33'(haddr_i[31:BL]) >= 33'(MEM_DEPTH);
        err_o       = size_err || align_err || range_err;
    end

endmodule

// File: rtl/ahbl_sram_bridge_par.sv
// AHB-Lite slave to synchronous SRAM bridge: zero-wait writes, RD_LATENCY+1 cycle reads,
// two-cycle ERROR response.
module ahbl_sram_bridge_par
    import ahbl_sram_pkg::*;
#(
    parameter  int DWIDTH     = 32,
    parameter  int MEM_DEPTH  = 65536,
    parameter  int RD_LATENCY = 1,
    localparam int NB         = DWIDTH / 8,
    localparam int MEM_AWIDTH = ceil_log2(MEM_DEPTH)
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    input  logic                  HSEL,
    input  logic                  HREADYIN,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HBURST,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HADDR,
    input  logic                  HWRITE,
    input  logic [DWIDTH-1:0]     HWDATA,
    output logic [DWIDTH-1:0]     HRDATA,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [MEM_AWIDTH-1:0] mem_addr,
    output logic [NB-1:0]         mem_byteen,
    output logic [DWIDTH-1:0]     mem_wdata,
    input  logic [DWIDTH-1:0]     mem_rdata
);

    localparam logic [1:0] RD_LOAD = 2'(RD_LATENCY);

    bridge_state_e         state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [MEM_AWIDTH-1:0] addr_q, addr_d;
    logic [NB-1:0]         be_q, be_d;

    logic [NB-1:0]         dec_be;
    logic [MEM_AWIDTH-1:0] dec_addr;
    logic                  dec_err;
    logic                  hready;
    logic                  accept;
    logic                  rd_first;
    logic                  rd_last;
    logic                  unused_inputs;

    assign unused_inputs = ^{HBURST, HTRANS[0]};

    ahbl_lane_decode #(
        .DWIDTH    (DWIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_decode (
        .haddr_i     (HADDR),
        .hsize_i     (HSIZE),
        .byteen_o    (dec_be),
        .word_addr_o (dec_addr),
        .err_o       (dec_err)
    );

    // The read counter is loaded with RD_LATENCY and reaches zero on the cycle data is valid.
    assign rd_first = (state_q == ST_RD_WAIT) && (cnt_q == RD_LOAD);
    assign rd_last  = (state_q == ST_RD_WAIT) && (cnt_q == 2'd0);
    assign hready   = !(((state_q == ST_RD_WAIT) && !rd_last) || (state_q == ST_ERR1));
    assign accept   = hready && HSEL && HREADYIN && HTRANS[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        be_d    = be_q;
        if (hready) begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
            if (accept) begin
                addr_d = dec_addr;
                be_d   = dec_be;
                if (dec_err) begin
                    state_d = ST_ERR1;
                end else if (HWRITE) begin
                    state_d = ST_WR_DATA;
                end else begin
                    state_d = ST_RD_WAIT;
                    cnt_d   = RD_LOAD;
                end
            end
        end else begin
            case (state_q)
                ST_RD_WAIT: cnt_d   = cnt_q - 2'd1;
                ST_ERR1:    state_d = ST_ERR2;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
        end
    end

    // All outputs decode from registered state so reset forces them at once.
    assign HREADYOUT  = hready;
    assign HRESP      = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA     = rd_last ? mem_rdata : '0;
    assign mem_ren    = rd_first;
    assign mem_wen    = (state_q == ST_WR_DATA);
    assign mem_addr   = addr_q;
    assign mem_byteen = be_q;
    assign mem_wdata  = (state_q == ST_WR_DATA) ? HWDATA : '0;

endmodule
